vram_loader: RTL and testbench
==============================

Name: vram_loader

Overview:
- Sequencer that copies a block of words from the registered image ROM into the dual-port video RAM's write port.
- Sits directly upstream of the video RAM. The pixel-timing/scan-out stage reads the video RAM on its own port.
- Replaces the free-running write-address counter with a start/busy/done controlled transfer, which allows frame-synchronous reloads.

Parameters:
- ROM_AW, 12, image ROM address width.
- VRAM_AW, 11, video RAM write address width.
- DW, 8, data word width.
- ROM_LAT, 1, ROM read latency in clocks. Legal values are 1 or 2.
- COUNT, 2048, words per transfer. Range 1..2^VRAM_AW.

Ports:
- clk  in  1  write-side clock; all logic posedge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- src_base  in  ROM_AW  first ROM address; captured when start is accepted.
- stall  in  1  while high, no new ROM read is issued.
- busy  out  1  high from the cycle after start is accepted through the last write.
- done  out  1  one-cycle pulse after the last write.
- rom_ad  out  ROM_AW  ROM read address.
- rom_data  in  DW  ROM read data, valid ROM_LAT clocks after rom_ad.
- vram_we  out  1  video RAM write enable / clock enable.
- vram_ad  out  VRAM_AW  video RAM write address.
- vram_data  out  DW  video RAM write data. Equals rom_data passed through, aligned with vram_we.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, busy=0, done=0, vram_we=0, rom_ad=0, vram_ad=0, read index=0, in-flight valid pipe cleared.
- Reset asserted mid-transfer aborts immediately. No further writes. done is not pulsed.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start=1 → capture src_base, rd_idx=0, go to ISSUE. Otherwise stay.
  - ISSUE: busy=1. Each cycle with stall=0: rom_ad = src_base + rd_idx (mod 2^ROM_AW, wrap silently), push valid+rd_idx into the ROM_LAT-deep tag pipe, rd_idx++. When rd_idx reaches COUNT-1 and it is issued, go to DRAIN.
  - ISSUE with stall=1: rom_ad holds, push an invalid bubble, rd_idx holds.
  - DRAIN: busy=1. No issues. Stall has no effect. When the tag pipe is empty after its final write, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle, then IDLE.
- start while not in IDLE (including DONE) is ignored. No queuing.
- Write side: when a valid tag emerges from the pipe (aligned with rom_data), in the same cycle vram_we=1, vram_ad=tag[VRAM_AW-1:0], vram_data=rom_data.
- vram_we=0 whenever no valid tag emerges. vram_ad and vram_data are don't-care while vram_we=0.
- Stall only blocks issue. In-flight reads always complete and write, so no data is lost for any ROM_LAT.
- Timing, no stall, start accepted at edge 0:
  - rom_ad=src_base valid after edge 1.
  - First vram_we high in the cycle after edge 1+ROM_LAT.
  - Last write in the cycle after edge COUNT+ROM_LAT.
  - done high in the following cycle.
- Total latency from start to done: COUNT+ROM_LAT+1 cycles plus the number of stalled issue cycles.
- Address arithmetic is unsigned. src_base+rd_idx wraps modulo 2^ROM_AW. vram_ad never exceeds COUNT-1.
- COUNT=1: ISSUE lasts one cycle and goes straight to DRAIN.

Decomposition:
- Shared video package holds:
  - the FSM state enum (IDLE/ISSUE/DRAIN/DONE);
  - the LCD geometry constants (480x272, porches, pulse widths) for the scan-out stage;
  - the default image/VRAM address widths, so loader and scan-out agree.
- One sub-module: vram_loader_tagpipe, a ROM_LAT-deep shift register of {valid, index} with synchronous advance every cycle and asynchronous clear.

Test Plan:
- Basic copy: ROM_LAT=1, COUNT=16, src_base=0x010, ROM word = address[7:0].
  → 16 writes, vram_ad 0..15, vram_data 0x10..0x1F, no gaps.
  → done exactly 18 cycles after start.
- Wrap: src_base=0xFFE, COUNT=4.
  → rom_ad sequence FFE, FFF, 000, 001.
  → vram_data 0xFE, 0xFF, 0x00, 0x01 at vram_ad 0..3.
- Stall: stall high for 3 cycles after the 5th issue, COUNT=16.
  → still 16 writes with correct data and monotonic vram_ad.
  → vram_we low for exactly 3 cycles.
  → done at cycle 21.
- ROM_LAT=2 with stall toggling every cycle.
  → every index 0..COUNT-1 written exactly once with matching data.
  → no write after done.
- Control corner cases:
  - start pulsed while busy and in the DONE cycle → ignored; exactly one done pulse.
  - start in IDLE the cycle after done → accepted.
- Reset mid-transfer at the 7th write.
  → vram_we=0 and busy=0 immediately, with no done pulse.
  → after release, a new start copies all COUNT words from index 0.

Source files
------------

// File: rtl/vram_loader_pkg.sv
// Shared video definitions: loader FSM states, LCD panel timing for the scan-out
// stage, and the default memory widths so loader and scan-out agree.
package vram_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } load_state_t;

    // 480x272 panel timing in pixel clocks / lines
    localparam int LCD_H_ACTIVE = 480;
    localparam int LCD_H_FRONT  = 2;
    localparam int LCD_H_PULSE  = 41;
    localparam int LCD_H_BACK   = 2;
    localparam int LCD_H_TOTAL  = LCD_H_ACTIVE + LCD_H_FRONT + LCD_H_PULSE + LCD_H_BACK;

    localparam int LCD_V_ACTIVE = 272;
    localparam int LCD_V_FRONT  = 2;
    localparam int LCD_V_PULSE  = 10;
    localparam int LCD_V_BACK   = 2;
    localparam int LCD_V_TOTAL  = LCD_V_ACTIVE + LCD_V_FRONT + LCD_V_PULSE + LCD_V_BACK;

    localparam int DEF_ROM_AW  = 12;
    localparam int DEF_VRAM_AW = 11;
    localparam int DEF_DW      = 8;

endpackage

// File: rtl/vram_loader_tagpipe.sv
// Fixed-depth shift register of {valid, index} tags that tracks ROM reads in flight
// so each returning word can be written to the index it was fetched for.
module vram_loader_tagpipe #(
    parameter int DEPTH = 1,
    parameter int IW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [IW-1:0] in_idx,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    output logic          pending
);

    logic [DEPTH-1:0] valid_q;
    logic [IW-1:0]    idx_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            idx_q[0]   <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    // Tags still travelling behind the output stage; the output stage itself is excluded
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | valid_q[i];
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/vram_loader.sv
// Start/busy/done controlled block copy from the registered image ROM into the
// write port of the dual-port video RAM.
module vram_loader
    import vram_loader_pkg::*;
#(
    parameter int ROM_AW  = DEF_ROM_AW,
    parameter int VRAM_AW = DEF_VRAM_AW,
    parameter int DW      = DEF_DW,
    parameter int ROM_LAT = 1,
    parameter int COUNT   = 2048
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ROM_AW-1:0]  src_base,
    input  logic               stall,
    output logic               busy,
    output logic               done,
    output logic [ROM_AW-1:0]  rom_ad,
    input  logic [DW-1:0]      rom_data,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_ad,
    output logic [DW-1:0]      vram_data
);

    localparam logic [VRAM_AW-1:0] LAST_IDX = VRAM_AW'(COUNT - 1);

    load_state_t        state;
    logic [ROM_AW-1:0]  base_q;
    logic [VRAM_AW-1:0] rd_idx;
    logic               issue_valid;
    logic [VRAM_AW-1:0] issue_idx;
    logic               pending;
    logic               tag_valid;
    logic [VRAM_AW-1:0] tag_idx;

    // The issue tag is registered alongside rom_ad, so the tag pipe only has to
    // cover the ROM's own latency to line up with rom_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rom_ad      <= '0;
            base_q      <= '0;
            rd_idx      <= '0;
            issue_valid <= 1'b0;
            issue_idx   <= '0;
        end else begin
            issue_valid <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= src_base;
                        rd_idx <= '0;
                        busy   <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        rom_ad      <= base_q + ROM_AW'(rd_idx);
                        issue_valid <= 1'b1;
                        issue_idx   <= rd_idx;
                        if (rd_idx == LAST_IDX) begin
                            state <= DRAIN;
                        end else begin
                            rd_idx <= rd_idx + VRAM_AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Only the final write (if any) remains at the pipe output
                    if (!issue_valid && !pending) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    vram_loader_tagpipe #(
        .DEPTH (ROM_LAT),
        .IW    (VRAM_AW)
    ) u_tagpipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue_valid),
        .in_idx    (issue_idx),
        .out_valid (tag_valid),
        .out_idx   (tag_idx),
        .pending   (pending)
    );

    assign vram_we   = tag_valid;
    assign vram_ad   = tag_idx;
    assign vram_data = rom_data;

endmodule

// File: tb/tb_vram_loader.sv
// Self-checking bench for vram_loader: three instances (latency 1/2, counts 16/4)
// checked against a cycle-level model of the issue/write schedule.
module tb_vram_loader;

    localparam int ROM_AW  = 12;
    localparam int VRAM_AW = 11;
    localparam int DW      = 8;
    localparam int NU      = 3;
    localparam int LOGN    = 512;
    localparam int LAT_A = 1, CNT_A = 16;
    localparam int LAT_B = 2, CNT_B = 16;
    localparam int LAT_C = 1, CNT_C = 4;

    typedef struct {
        int              unit;
        logic [11:0]     base;
        logic [7:0]      key;
        int              stall_mode;
        int              exp_lat;
        int              exp_gap;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NU-1:0]              start_v, stall_v, busy_v, done_v, we_v;
    logic [NU-1:0][ROM_AW-1:0]  base_v, rad_v;
    logic [NU-1:0][DW-1:0]      rdata_v, vdata_v;
    logic [NU-1:0][VRAM_AW-1:0] vad_v;
    logic [DW-1:0]              rom_b_s1;
    logic [7:0]                 rom_key = 8'h00;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    int wr_ad  [NU][LOGN];
    int wr_dat [NU][LOGN];
    int wr_cyc [NU][LOGN];
    int wr_n     [NU] = '{default: 0};
    int done_n   [NU] = '{default: 0};
    int done_cyc [NU] = '{default: 0};

    vram_loader #(.ROM_AW(ROM_AW), .VRAM_AW(VRAM_AW), .DW(DW), .ROM_LAT(LAT_A), .COUNT(CNT_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .src_base(base_v[0]), .stall(stall_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .rom_ad(rad_v[0]), .rom_data(rdata_v[0]),
        .vram_we(we_v[0]), .vram_ad(vad_v[0]), .vram_data(vdata_v[0]));

    vram_loader #(.ROM_AW(ROM_AW), .VRAM_AW(VRAM_AW), .DW(DW), .ROM_LAT(LAT_B), .COUNT(CNT_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .src_base(base_v[1]), .stall(stall_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .rom_ad(rad_v[1]), .rom_data(rdata_v[1]),
        .vram_we(we_v[1]), .vram_ad(vad_v[1]), .vram_data(vdata_v[1]));

    vram_loader #(.ROM_AW(ROM_AW), .VRAM_AW(VRAM_AW), .DW(DW), .ROM_LAT(LAT_C), .COUNT(CNT_C)) dut_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .src_base(base_v[2]), .stall(stall_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .rom_ad(rad_v[2]), .rom_data(rdata_v[2]),
        .vram_we(we_v[2]), .vram_ad(vad_v[2]), .vram_data(vdata_v[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_word(logic [11:0] a);
        return a[7:0] ^ rom_key;
    endfunction

    // Registered image ROMs, one per instance, at that instance's latency
    always @(posedge clk) begin
        rdata_v[0] <= rom_word(rad_v[0]);
        rom_b_s1   <= rom_word(rad_v[1]);
        rdata_v[1] <= rom_b_s1;
        rdata_v[2] <= rom_word(rad_v[2]);
    end

    // Mid-cycle write/done log
    always @(negedge clk) begin
        for (int u = 0; u < NU; u++) begin
            if (we_v[u]) begin
                if (wr_n[u] < LOGN) begin
                    wr_ad[u][wr_n[u]]  = int'(vad_v[u]);
                    wr_dat[u][wr_n[u]] = int'(vdata_v[u]);
                    wr_cyc[u][wr_n[u]] = cyc;
                end
                wr_n[u] = wr_n[u] + 1;
            end
            if (done_v[u]) begin
                done_n[u]   = done_n[u] + 1;
                done_cyc[u] = cyc;
            end
        end
    end

    function automatic int lat_of(int u);
        case (u)
            1:       return LAT_B;
            2:       return LAT_C;
            default: return LAT_A;
        endcase
    endfunction

    function automatic int cnt_of(int u);
        case (u)
            1:       return CNT_B;
            2:       return CNT_C;
            default: return CNT_A;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic waitDone(input int u, output int found);
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            if (done_v[u]) found = 1;
            else step();
        end
    endtask

    // One complete transfer; expected write slots come from the issue schedule:
    // each unstalled issue cycle k launches the next index at edge k+1, and its
    // word is written ROM_LAT cycles later; done follows the last write.
    task automatic applyStimulus(input vec_t v);
        int u, lat, cnt, issued, w0, d0, c0, done_seen, j, exp_done;
        bit pat [256];
        int exp_rel [64];
        logic [11:0] a;
        u   = v.unit;
        lat = lat_of(u);
        cnt = cnt_of(u);
        rom_key = v.key;
        for (int k = 0; k < 256; k++) begin
            case (v.stall_mode)
                1:       pat[k] = (k >= 5 && k <= 7);
                2:       pat[k] = (k % 2) == 1;
                3:       pat[k] = ($urandom_range(0, 3) == 0);
                default: pat[k] = 1'b0;
            endcase
        end
        issued = 0;
        for (int k = 0; k < 256 && issued < cnt; k++) begin
            if (!pat[k]) begin
                exp_rel[issued] = k + 1 + lat;
                issued = issued + 1;
            end
        end
        exp_done = (v.exp_lat >= 0) ? v.exp_lat : exp_rel[cnt-1] + 1;

        w0 = wr_n[u];
        d0 = done_n[u];
        base_v[u]  = v.base;
        start_v[u] = 1'b1;
        step();
        start_v[u] = 1'b0;
        c0 = cyc;
        checkOutput("busy_after_start", int'(busy_v[u]), 1);

        done_seen = 0;
        for (int k = 0; k < 200 && done_seen == 0; k++) begin
            stall_v[u] = pat[k];
            step();
            if (done_v[u]) done_seen = 1;
        end
        checkOutput("done_seen", done_seen, 1);
        checkOutput("busy_in_done", int'(busy_v[u]), 0);
        stall_v[u] = 1'b0;
        repeat (4) step();

        checkOutput("write_count", wr_n[u] - w0, cnt);
        checkOutput("done_count", done_n[u] - d0, 1);
        checkOutput("done_cycle", done_cyc[u] - c0, exp_done);
        for (int i = 0; i < cnt && i < wr_n[u] - w0; i++) begin
            j = w0 + i;
            if (j < LOGN) begin
                a = v.base + 12'(i);
                checkOutput("vram_ad", wr_ad[u][j], i);
                checkOutput("vram_data", wr_dat[u][j], int'(a[7:0] ^ v.key));
                checkOutput("write_cycle", wr_cyc[u][j] - c0, exp_rel[i]);
            end
        end
        if (v.exp_gap >= 0 && wr_n[u] - w0 >= cnt && w0 + cnt <= LOGN)
            checkOutput("we_gap", wr_cyc[u][w0+cnt-1] - wr_cyc[u][w0] + 1 - cnt, v.exp_gap);
    endtask

    initial begin
        vec_t tbl [10];
        vec_t one;
        int w0, d0, c0, c1, found;

        start_v = '0;
        stall_v = '0;
        base_v  = '0;

        tbl[0] = '{0, 12'h010, 8'h00, 0, 18, 0};
        tbl[1] = '{2, 12'hFFE, 8'h00, 0, 6, 0};
        tbl[2] = '{0, 12'h010, 8'h00, 1, 21, 3};
        tbl[3] = '{1, 12'h3F0, 8'h00, 2, 34, -1};
        for (int i = 4; i < 10; i++) begin
            tbl[i] = '{i % 3, 12'($urandom), 8'($urandom), 3, -1, -1};
        end

        repeat (3) step();
        for (int u = 0; u < NU; u++) begin
            checkOutput("reset_busy", int'(busy_v[u]), 0);
            checkOutput("reset_done", int'(done_v[u]), 0);
            checkOutput("reset_we", int'(we_v[u]), 0);
            checkOutput("reset_rom_ad", int'(rad_v[u]), 0);
            checkOutput("reset_vram_ad", int'(vad_v[u]), 0);
        end
        rst = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i]);
        end

        // ROM address wraps silently past the top of the image ROM
        $display("[TB] wrap address sequence");
        rom_key = 8'h00;
        base_v[2]  = 12'hFFE;
        start_v[2] = 1'b1;
        step();
        start_v[2] = 1'b0;
        step(); checkOutput("wrap_rom_ad0", int'(rad_v[2]), 12'hFFE);
        step(); checkOutput("wrap_rom_ad1", int'(rad_v[2]), 12'hFFF);
        step(); checkOutput("wrap_rom_ad2", int'(rad_v[2]), 12'h000);
        step(); checkOutput("wrap_rom_ad3", int'(rad_v[2]), 12'h001);
        waitDone(2, found);
        checkOutput("wrap_done_seen", found, 1);
        repeat (3) step();

        // start while busy and during DONE is ignored; start right after is taken
        $display("[TB] control corner cases");
        w0 = wr_n[0];
        d0 = done_n[0];
        base_v[0]  = 12'h040;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        c0 = cyc;
        repeat (2) step();
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        waitDone(0, found);
        checkOutput("ctrl_first_done_seen", found, 1);
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        checkOutput("ctrl_busy_after_done_start", int'(busy_v[0]), 0);
        checkOutput("ctrl_done_one_cycle", int'(done_v[0]), 0);
        checkOutput("ctrl_first_done_cycle", done_cyc[0] - c0, 18);
        checkOutput("ctrl_first_done_count", done_n[0] - d0, 1);
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        c1 = cyc;
        checkOutput("ctrl_restart_busy", int'(busy_v[0]), 1);
        waitDone(0, found);
        checkOutput("ctrl_second_done_seen", found, 1);
        repeat (4) step();
        checkOutput("ctrl_second_done_cycle", done_cyc[0] - c1, 18);
        checkOutput("ctrl_total_done_count", done_n[0] - d0, 2);
        checkOutput("ctrl_total_writes", wr_n[0] - w0, 32);

        // Reset in the cycle of the 7th write aborts with no done pulse
        $display("[TB] reset mid-transfer");
        w0 = wr_n[0];
        d0 = done_n[0];
        base_v[0]  = 12'h0A0;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            step();
            if (we_v[0] && vad_v[0] == 11'd6) found = 1;
        end
        checkOutput("reset_seventh_write_found", found, 1);
        rst = 1'b0;
        #1;
        checkOutput("abort_we", int'(we_v[0]), 0);
        checkOutput("abort_busy", int'(busy_v[0]), 0);
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();
        checkOutput("abort_writes", wr_n[0] - w0, 6);
        checkOutput("abort_no_done", done_n[0] - d0, 0);
        one = '{0, 12'h0A0, 8'h5A, 0, 18, 0};
        applyStimulus(one);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
